// File: rtl/ins_fetch_if.sv
// Bus bundle between the instruction fetch unit and its environment
// (control unit, instruction memory, instruction register).
interface ins_fetch_if #(
    parameter int PC_W  = 8,
    parameter int INS_W = 24
);
    // Control unit side
    logic             start;
    logic             next;
    logic             branch_en;
    logic [PC_W-1:0]  branch_addr;
    logic             halt;
    // Memory side: mem_read is the request; mem_ready marks mem_data valid.
    // A word transfers on the rising edge where mem_read and mem_ready are both high.
    logic             mem_read;
    logic [PC_W-1:0]  mem_addr;
    logic             mem_ready;
    logic [INS_W-1:0] mem_data;
    // Instruction register side
    logic             ir_write;
    logic [INS_W-1:0] ir_data;
    logic [PC_W-1:0]  pc;
    logic             busy;

    modport slave (
        input  start, next, branch_en, branch_addr, halt, mem_ready, mem_data,
        output mem_read, mem_addr, ir_write, ir_data, pc, busy
    );

    modport master (
        output start, next, branch_en, branch_addr, halt, mem_ready, mem_data,
        input  mem_read, mem_addr, ir_write, ir_data, pc, busy
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch unit: reads one word per request from instruction memory,
// hands it to the IR, then waits in HOLD for the control unit.
module ins_fetch #(
    parameter int              PC_W     = 8,
    parameter int              INS_W    = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       reset,
    ins_fetch_if.slave bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] ir_data_q, ir_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            ir_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            ir_data_q  <= ir_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        ir_data_d  = ir_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    ir_data_d = bus.mem_data;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // fetch_pc wraps naturally at 2^PC_W
                pc_d       = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(1);
                state_d    = HOLD;
            end
            HOLD: begin
                if (bus.halt) begin
                    state_d = IDLE;
                end else if (bus.branch_en) begin
                    fetch_pc_d = bus.branch_addr;
                    state_d    = FETCH;
                end else if (bus.next) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read = (state_q == FETCH);
    assign bus.mem_addr = fetch_pc_q;
    assign bus.ir_write = (state_q == LOAD);
    assign bus.ir_data  = ir_data_q;
    assign bus.pc       = pc_q;
    assign bus.busy     = (state_q != IDLE);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: a behavioural model predicts every output each
// cycle, and literal expectations pin the key scenarios.
module tb_ins_fetch;
    localparam int PC_W  = 8;
    localparam int INS_W = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    ins_fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    ins_fetch #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Instruction memory contents
    logic [INS_W-1:0] mem_arr [256];
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = {8'hC0, 8'(i), ~8'(i)};
        mem_arr[0] = 24'd100;
    end
    assign bus.mem_data = mem_arr[bus.mem_addr];

    // Behavioural model: phase 0=idle 1=requesting 2=delivering 3=waiting
    int               m_ph  = 0;
    logic [PC_W-1:0]  m_fpc = '0;
    logic [PC_W-1:0]  m_pc  = '0;
    logic [INS_W-1:0] m_ir  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph <= 0; m_fpc <= '0; m_pc <= '0; m_ir <= '0;
        end else begin
            case (m_ph)
                0: if (bus.start) m_ph <= 1;
                1: if (bus.mem_ready) begin m_ir <= mem_arr[m_fpc]; m_ph <= 2; end
                2: begin m_pc <= m_fpc; m_fpc <= m_fpc + 8'd1; m_ph <= 3; end
                default: begin
                    if (bus.halt) m_ph <= 0;
                    else if (bus.branch_en) begin m_fpc <= bus.branch_addr; m_ph <= 1; end
                    else if (bus.next) m_ph <= 1;
                end
            endcase
        end
    end

    int n_vec  = 0;
    int n_err  = 0;
    int ir_cnt = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            cmp("m.mem_read", 32'(bus.mem_read), 32'(m_ph == 1));
            if (m_ph == 1) cmp("m.mem_addr", 32'(bus.mem_addr), 32'(m_fpc));
            cmp("m.ir_write", 32'(bus.ir_write), 32'(m_ph == 2));
            cmp("m.ir_data", 32'(bus.ir_data), 32'(m_ir));
            cmp("m.pc", 32'(bus.pc), 32'(m_pc));
            cmp("m.busy", 32'(bus.busy), 32'(m_ph != 0));
        end
        if (bus.ir_write === 1'b1) ir_cnt++;
    endtask

    task automatic clear_ctrl();
        bus.start = 0; bus.next = 0; bus.branch_en = 0; bus.halt = 0; bus.branch_addr = '0;
    endtask

    initial begin
        clear_ctrl();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        cmp("rst.busy", 32'(bus.busy), 0);
        cmp("rst.mem_read", 32'(bus.mem_read), 0);
        cmp("rst.ir_write", 32'(bus.ir_write), 0);
        cmp("rst.ir_data", 32'(bus.ir_data), 0);
        cmp("rst.pc", 32'(bus.pc), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();
        cmp("idle.busy", 32'(bus.busy), 0);

        // Basic fetch
        ir_cnt = 0;
        bus.mem_ready = 1'b1; bus.start = 1'b1;
        tick();
        cmp("basic.mem_read", 32'(bus.mem_read), 1);
        cmp("basic.mem_addr", 32'(bus.mem_addr), 32'h00);
        bus.start = 1'b0;
        tick();
        cmp("basic.ir_write", 32'(bus.ir_write), 1);
        cmp("basic.ir_data", 32'(bus.ir_data), 100);
        tick();
        cmp("basic.ir_write_off", 32'(bus.ir_write), 0);
        cmp("basic.pc", 32'(bus.pc), 0);
        cmp("basic.state_hold", 32'(dbg_state), 3);
        cmp("basic.pulses", 32'(ir_cnt), 1);

        // Memory wait: four FETCH cycles with stable request
        ir_cnt = 0;
        bus.mem_ready = 1'b0; bus.next = 1'b1;
        tick();
        cmp("wait.mem_addr0", 32'(bus.mem_addr), 32'h01);
        bus.next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("wait.mem_read", 32'(bus.mem_read), 1);
            cmp("wait.mem_addr", 32'(bus.mem_addr), 32'h01);
            cmp("wait.no_ir", 32'(bus.ir_write), 0);
        end
        bus.mem_ready = 1'b1;
        tick();
        cmp("wait.ir_data", 32'(bus.ir_data), 32'hC001FE);
        tick(); tick();
        cmp("wait.pulses", 32'(ir_cnt), 1);
        cmp("wait.pc", 32'(bus.pc), 32'h01);

        // Control inputs during FETCH/LOAD are ignored
        bus.next = 1'b1;
        tick();
        cmp("ign.mem_addr", 32'(bus.mem_addr), 32'h02);
        bus.branch_en = 1'b1; bus.branch_addr = 8'h77; bus.halt = 1'b1;
        tick();
        cmp("ign.ir_write", 32'(bus.ir_write), 1);
        tick();
        cmp("ign.pc", 32'(bus.pc), 32'h02);
        cmp("ign.busy", 32'(bus.busy), 1);
        clear_ctrl();
        bus.next = 1'b1;
        tick();
        cmp("ign.next_addr", 32'(bus.mem_addr), 32'h03);
        bus.next = 1'b0;
        tick(); tick();
        cmp("ign.pc3", 32'(bus.pc), 32'h03);

        // branch_en beats next
        bus.branch_en = 1'b1; bus.branch_addr = 8'h40; bus.next = 1'b1;
        tick();
        cmp("br.mem_addr", 32'(bus.mem_addr), 32'h40);
        clear_ctrl();
        tick();
        cmp("br.ir_data", 32'(bus.ir_data), 32'hC040BF);
        tick();
        cmp("br.pc", 32'(bus.pc), 32'h40);

        // Wrap FF -> 00
        bus.branch_en = 1'b1; bus.branch_addr = 8'hFF;
        tick();
        cmp("wrap.mem_addr_ff", 32'(bus.mem_addr), 32'hFF);
        clear_ctrl();
        tick(); tick();
        cmp("wrap.pc_ff", 32'(bus.pc), 32'hFF);
        cmp("wrap.ir_ff", 32'(bus.ir_data), 32'hC0FF00);
        bus.next = 1'b1;
        tick();
        cmp("wrap.mem_addr_00", 32'(bus.mem_addr), 32'h00);
        bus.next = 1'b0;
        tick(); tick();
        cmp("wrap.pc_00", 32'(bus.pc), 32'h00);
        cmp("wrap.ir_00", 32'(bus.ir_data), 100);

        // halt beats branch_en and next; restart continues from 01
        bus.halt = 1'b1; bus.branch_en = 1'b1; bus.branch_addr = 8'h55; bus.next = 1'b1;
        tick();
        cmp("halt.busy", 32'(bus.busy), 0);
        cmp("halt.mem_read", 32'(bus.mem_read), 0);
        cmp("halt.state", 32'(dbg_state), 0);
        clear_ctrl();
        tick(); tick();
        cmp("halt.idle_mem_read", 32'(bus.mem_read), 0);
        cmp("halt.pc_kept", 32'(bus.pc), 32'h00);
        bus.start = 1'b1;
        tick();
        cmp("halt.restart_addr", 32'(bus.mem_addr), 32'h01);
        bus.start = 1'b0;
        tick(); tick();
        cmp("halt.restart_pc", 32'(bus.pc), 32'h01);

        // start is ignored in HOLD
        bus.start = 1'b1;
        tick();
        cmp("hold.start_ign", 32'(dbg_state), 3);
        cmp("hold.no_read", 32'(bus.mem_read), 0);
        bus.start = 1'b0;

        // Reset while waiting in FETCH
        bus.mem_ready = 1'b0; bus.next = 1'b1;
        tick();
        cmp("rstf.mem_addr", 32'(bus.mem_addr), 32'h02);
        bus.next = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        cmp("rstf.mem_read", 32'(bus.mem_read), 0);
        cmp("rstf.busy", 32'(bus.busy), 0);
        cmp("rstf.ir_data", 32'(bus.ir_data), 0);
        cmp("rstf.pc", 32'(bus.pc), 0);
        reset = 1'b0;
        bus.mem_ready = 1'b1; bus.start = 1'b1;
        tick();
        cmp("rstf.restart_addr", 32'(bus.mem_addr), 32'h00);
        bus.start = 1'b0;
        tick();
        cmp("rstf.latency_ir_write", 32'(bus.ir_write), 1);
        tick();
        cmp("rstf.ir_data_after", 32'(bus.ir_data), 100);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Parameters
REQ-001 SHALL have parameter PC_W, default 8, instruction address width.
REQ-002 SHALL have parameter INS_W, default 24, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.

Interface
REQ-004 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have: start  input  1  begin fetching from IDLE.
REQ-007 SHALL have: next  input  1  control unit done with current instruction; fetch the following one.
REQ-008 SHALL have: branch_en  input  1  redirect the next fetch to branch_addr.
REQ-009 SHALL have: branch_addr  input  PC_W  branch target.
REQ-010 SHALL have: halt  input  1  stop fetching, return to IDLE.
REQ-011 SHALL have: mem_read  output  1  instruction memory read request.
REQ-012 SHALL have: mem_addr  output  PC_W  read address.
REQ-013 SHALL have: mem_ready  input  1  memory data valid this cycle.
REQ-014 SHALL have: mem_data  input  INS_W  instruction word from memory.
REQ-015 SHALL have: ir_write  output  1  write strobe to the instruction register.
REQ-016 SHALL have: ir_data  output  INS_W  instruction word to the instruction register.
REQ-017 SHALL have: pc  output  PC_W  address of the instruction last written to the IR.
REQ-018 SHALL have: busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement a four-state FSM: IDLE, FETCH, LOAD, HOLD.
REQ-020 SHALL, in IDLE, go to FETCH on the edge where start=1; otherwise stay in IDLE. start SHALL be ignored in all other states.
REQ-021 SHALL, in FETCH, drive mem_read=1 and mem_addr=fetch_pc. It SHALL hold both stable until mem_ready=1 is sampled, with no timeout.
REQ-022 SHALL, on the FETCH edge with mem_ready=1, register mem_data into ir_data and go to LOAD.
REQ-023 SHALL, in LOAD, drive ir_write=1 for exactly one cycle. On that edge: pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^PC_W (wraps all-ones to 0), next state HOLD.
REQ-024 SHALL, in HOLD, apply priority halt > branch_en > next on each edge:
- halt: go to IDLE.
- branch_en: fetch_pc<=branch_addr, go to FETCH.
- next: go to FETCH.
- none: stay in HOLD.
REQ-025 SHALL ignore halt, branch_en and next outside HOLD.
REQ-026 SHALL keep mem_read=0 outside FETCH and ir_write=0 outside LOAD.
REQ-027 SHALL hold ir_data and pc constant except at the update points in REQ-022 and REQ-023.
REQ-028 SHALL, on IDLE->FETCH via start, fetch from the current fetch_pc: RESET_PC after reset, or the continuation address after a halt.
REQ-029 SHALL meet this latency: with next sampled at edge N and mem_ready=1 during the first FETCH cycle, ir_write is high in the cycle after edge N+1.

Reset
REQ-030 SHALL, on an edge with reset=1, force from any state, including mid-FETCH:
- state=IDLE, fetch_pc=RESET_PC, pc=0, ir_data=0.
- mem_read=0, ir_write=0, busy=0.
REQ-031 SHALL give reset priority over all other inputs. Outputs SHALL show reset values from the cycle after the reset edge.

Verification
REQ-032 Basic fetch: reset, then start=1 for one cycle, mem_ready=1 immediately, mem_data=24'd100 -> mem_addr=0, ir_write pulses once with ir_data=100, pc=0, FSM in HOLD.
REQ-033 Memory wait: mem_ready held low for 3 FETCH cycles -> mem_read and mem_addr stable for 4 cycles, single ir_write pulse after mem_ready rises.
REQ-034 Sequential and wrap: fetch_pc=8'hFF, pulse next -> mem_addr=FF; next fetch mem_addr=00; pc goes FF then 00.
REQ-035 Priority: in HOLD, assert branch_en=1 with branch_addr=8'h40 and next=1 -> mem_addr=40. Same with halt=1 -> IDLE, busy=0, no mem_read.
REQ-036 Reset mid-operation: reset asserted while in FETCH with mem_ready=0 -> next cycle mem_read=0, busy=0, ir_data=0; a following start fetches from address 0.
REQ-037 Ignored inputs: next or branch_en pulsed during FETCH or LOAD -> no change to the fetch sequence or addresses.
